trap_sequencer: RTL and testbench

TRAP_SEQUENCER -- requirements
Module: trap_sequencer

---
 rtl/trap_sequencer.sv | 155 +++++++++++++++
 tb/tb_trap_sequencer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// Trap entry/return sequencer: detects a rising trap request, redirects fetch to the
// cause's vector, tracks the handler, then redirects back to the saved exception PC.
module trap_sequencer #(
    parameter int              PC_W     = 8,
    parameter logic [PC_W-1:0] VEC_BASE = 8'hF0
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            trap_mode,
    input  logic [1:0]      trap_cause,
    input  logic [PC_W-1:0] pc_in,
    input  logic            rte,
    input  logic            fetch_ready,
    input  logic            clr_lost,
    output logic            pc_load,
    output logic [PC_W-1:0] pc_out,
    output logic [PC_W-1:0] epc,
    output logic            in_trap,
    output logic            trap_ack,
    output logic            busy,
    output logic            trap_lost
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_VECTOR  = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_e;

    state_e          state_q;
    logic            trap_prev_q;
    logic [1:0]      cause_q;
    logic [PC_W-1:0] epc_q;
    logic [PC_W-1:0] pc_out_q;
    logic            pc_load_q;
    logic            in_trap_q;
    logic            trap_ack_q;
    logic            busy_q;
    logic            trap_lost_q;

    logic            edge_s;
    logic            lost_s;

    function automatic logic [PC_W-1:0] vec_addr(input logic [1:0] cause);
        logic [PC_W+3:0] wide;
        wide = (PC_W+4)'(VEC_BASE) | ((PC_W+4)'(cause) << 2'd2);
        return wide[PC_W-1:0];
    endfunction

    assign edge_s = trap_mode & ~trap_prev_q;
    // Any trap edge outside IDLE is dropped, including the cycle a return completes.
    assign lost_s = edge_s & (state_q != ST_IDLE);

    // Sequencer state, captured trap context and all registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            trap_prev_q <= 1'b0;
            cause_q     <= 2'd0;
            epc_q       <= {PC_W{1'b0}};
            pc_out_q    <= {PC_W{1'b0}};
            pc_load_q   <= 1'b0;
            in_trap_q   <= 1'b0;
            trap_ack_q  <= 1'b0;
            busy_q      <= 1'b0;
            trap_lost_q <= 1'b0;
        end else begin
            trap_prev_q <= trap_mode;
            trap_ack_q  <= 1'b0;

            if (lost_s) begin
                trap_lost_q <= 1'b1;
            end else if (clr_lost) begin
                trap_lost_q <= 1'b0;
            end else begin
                trap_lost_q <= trap_lost_q;
            end

            case (state_q)
                ST_IDLE: begin
                    if (edge_s) begin
                        state_q   <= ST_VECTOR;
                        epc_q     <= pc_in;
                        cause_q   <= trap_cause;
                        pc_load_q <= 1'b1;
                        pc_out_q  <= vec_addr(trap_cause);
                        busy_q    <= 1'b1;
                    end else begin
                        pc_load_q <= 1'b0;
                        pc_out_q  <= {PC_W{1'b0}};
                        busy_q    <= 1'b0;
                    end
                    in_trap_q <= 1'b0;
                end
                ST_VECTOR: begin
                    if (fetch_ready) begin
                        state_q    <= ST_HANDLER;
                        pc_load_q  <= 1'b0;
                        pc_out_q   <= {PC_W{1'b0}};
                        in_trap_q  <= 1'b1;
                        trap_ack_q <= 1'b1;
                    end else begin
                        pc_load_q <= 1'b1;
                        pc_out_q  <= vec_addr(cause_q);
                        in_trap_q <= 1'b0;
                    end
                    busy_q <= 1'b1;
                end
                ST_HANDLER: begin
                    if (rte) begin
                        state_q   <= ST_RETURN;
                        pc_load_q <= 1'b1;
                        pc_out_q  <= epc_q;
                    end else begin
                        pc_load_q <= 1'b0;
                        pc_out_q  <= {PC_W{1'b0}};
                    end
                    in_trap_q <= 1'b1;
                    busy_q    <= 1'b1;
                end
                ST_RETURN: begin
                    if (fetch_ready) begin
                        state_q   <= ST_IDLE;
                        pc_load_q <= 1'b0;
                        pc_out_q  <= {PC_W{1'b0}};
                        in_trap_q <= 1'b0;
                        busy_q    <= 1'b0;
                    end else begin
                        pc_load_q <= 1'b1;
                        pc_out_q  <= epc_q;
                        in_trap_q <= 1'b1;
                        busy_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    pc_load_q <= 1'b0;
                    pc_out_q  <= {PC_W{1'b0}};
                    in_trap_q <= 1'b0;
                    busy_q    <= 1'b0;
                end
            endcase
        end
    end

    assign pc_load   = pc_load_q;
    assign pc_out    = pc_out_q;
    assign epc       = epc_q;
    assign in_trap   = in_trap_q;
    assign trap_ack  = trap_ack_q;
    assign busy      = busy_q;
    assign trap_lost = trap_lost_q;

endmodule

// File: tb/tb_trap_sequencer.sv
// Scoreboard bench for trap_sequencer: directed scenarios followed by random traffic,
// compared against a transaction-level reference model.
module tb_trap_sequencer;

    logic       rst;
    logic       clk;
    logic       trap_mode;
    logic [1:0] trap_cause;
    logic [7:0] pc_in;
    logic       rte;
    logic       fetch_ready;
    logic       clr_lost;
    logic       pc_load;
    logic [7:0] pc_out;
    logic [7:0] epc;
    logic       in_trap;
    logic       trap_ack;
    logic       busy;
    logic       trap_lost;

    int checks   = 0;
    int failures = 0;

    // Reference model: 0 idle, 1 waiting vector accept, 2 handler, 3 waiting return accept.
    int         m_phase = 0;
    logic       m_prev  = 1'b0;
    logic [7:0] m_epc   = 8'h00;
    logic       m_lost  = 1'b0;
    logic       m_ack   = 1'b0;
    logic [7:0] tq[$];
    logic [7:0] aq[$];

    logic       mon_prev_load = 1'b0;
    logic [7:0] mon_target    = 8'h00;

    trap_sequencer #(.PC_W(8), .VEC_BASE(8'hF0)) dut (
        .rst(rst), .clk(clk), .trap_mode(trap_mode), .trap_cause(trap_cause),
        .pc_in(pc_in), .rte(rte), .fetch_ready(fetch_ready), .clr_lost(clr_lost),
        .pc_load(pc_load), .pc_out(pc_out), .epc(epc), .in_trap(in_trap),
        .trap_ack(trap_ack), .busy(busy), .trap_lost(trap_lost)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] tb_vec(input logic [1:0] c);
        int v;
        v = 240 + 4 * int'(c);
        return v[7:0];
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        failures++;
        $display("FAIL %s: unexpected DUT output at %0t", name, $time);
    endtask

    // Drive one cycle of inputs, then advance the model across the clock edge.
    task automatic step(input logic tm, input logic [1:0] c, input logic [7:0] pc,
                        input logic r, input logic fr, input logic cl);
        logic edge_seen;
        trap_mode = tm; trap_cause = c; pc_in = pc; rte = r; fetch_ready = fr; clr_lost = cl;
        @(posedge clk);
        edge_seen = tm && !m_prev;
        m_ack = 1'b0;
        if (edge_seen && m_phase != 0) m_lost = 1'b1;
        else if (cl) m_lost = 1'b0;
        if (m_phase == 0 && edge_seen) begin
            m_epc = pc;
            tq.push_back(tb_vec(c));
            m_phase = 1;
        end else if (m_phase == 1 && fr) begin
            m_phase = 2;
            m_ack = 1'b1;
            aq.push_back(m_epc);
        end else if (m_phase == 2 && r) begin
            m_phase = 3;
            tq.push_back(m_epc);
        end else if (m_phase == 3 && fr) begin
            m_phase = 0;
        end
        m_prev = tm;
        #1;
    endtask

    // Mid-cycle asynchronous reset; trap_mode may be changed just before release.
    task automatic do_reset(input int n, input logic tm_release);
        rst = 1'b1;
        m_phase = 0; m_prev = 1'b0; m_epc = 8'h00; m_lost = 1'b0; m_ack = 1'b0;
        tq.delete();
        aq.delete();
        #1;
        chk("reset_outputs_zero", {pc_load, pc_out, epc, in_trap, trap_ack, busy, trap_lost}, 32'd0);
        repeat (n) @(posedge clk);
        #1;
        trap_mode = tm_release;
        rst = 1'b0;
    endtask

    // Monitor: level checks every cycle, redirect/ack targets popped from the scoreboard.
    always @(negedge clk) begin
        chk("busy", busy, m_phase != 0);
        chk("in_trap", in_trap, m_phase >= 2);
        chk("pc_load", pc_load, m_phase == 1 || m_phase == 3);
        chk("trap_lost", trap_lost, m_lost);
        chk("epc", epc, m_epc);
        chk("trap_ack", trap_ack, m_ack);
        if (pc_load && !mon_prev_load) begin
            if (tq.size() == 0) fail_now("redirect_unexpected");
            else begin
                mon_target = tq.pop_front();
                chk("redirect_target", pc_out, mon_target);
            end
        end else if (pc_load) begin
            chk("redirect_stable", pc_out, mon_target);
        end else begin
            chk("pc_out_idle_zero", pc_out, 32'd0);
        end
        if (trap_ack) begin
            if (aq.size() == 0) fail_now("ack_unexpected");
            else chk("ack_epc", epc, aq.pop_front());
        end
        mon_prev_load = pc_load;
    end

    initial begin
        logic tm;
        rst = 1'b1; trap_mode = 1'b0; trap_cause = 2'd0; pc_in = 8'h00;
        rte = 1'b0; fetch_ready = 1'b0; clr_lost = 1'b0;
        #1;
        chk("power_on_reset_zero", {pc_load, pc_out, epc, in_trap, trap_ack, busy, trap_lost}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Basic entry, handler, return
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'd2, 8'h23, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Backpressure in VECTOR
        step(1'b1, 2'd2, 8'h23, 1'b0, 1'b0, 1'b0);
        repeat (3) step(1'b1, 2'd1, 8'h99, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Lost traps in HANDLER and clearing
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'd1, 8'h55, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'd3, 8'h66, 1'b0, 1'b1, 1'b1);
        step(1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Edge in the cycle RETURN completes is lost, next IDLE edge taken
        step(1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd1, 8'h44, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1);
        step(1'b1, 2'd3, 8'h7A, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Edge together with rte in HANDLER
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'd2, 8'h11, 1'b1, 1'b0, 1'b0);
        step(1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b1);

        // Reset while stalled in VECTOR, no redirect afterwards
        step(1'b1, 2'd1, 8'h10, 1'b0, 1'b0, 1'b0);
        step(1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
        do_reset(2, 1'b0);
        repeat (4) step(1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);

        // trap_mode already high at release is an edge; holding it gives no retrigger
        do_reset(2, 1'b1);
        step(1'b1, 2'd3, 8'h5C, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
        step(1'b1, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b1, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);

        // Random traffic
        tm = 1'b1;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset($urandom_range(1, 3), 1'($urandom_range(0, 1)));
                tm = trap_mode;
            end else begin
                if ($urandom_range(0, 2) == 0) tm = ~tm;
                step(tm, 2'($urandom), 8'($urandom), $urandom_range(0, 3) == 0,
                     $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
            end
        end

        // Drain any open trap
        repeat (5) step(1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b0);
        chk("redirect_queue_drained", tq.size(), 32'd0);
        chk("ack_queue_drained", aq.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
